// File: rtl/rgb_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : rgb_pwm_fader
// Description : Three-channel PWM generator with a linear colour-fade
//               sequencer. It feeds the RGB0PWM/RGB1PWM/RGB2PWM inputs of an
//               SB_RGBA_DRV.
//
//               A producer offers a 24-bit target colour over valid/ready.
//               Each channel's duty then walks one step per fade step toward
//               its target. The PWM is period-aligned: duty changes take
//               effect only at a period boundary.
// Revision    : 1.0 - initial release
//
// Parameters  : PWM_PRESCALE  clocks per PWM counter step (>=1)
//               FADE_DIV      PWM periods per fade step (>=1)
// Ports       : clk          clock
//               rst_n        asynchronous active-low reset
//               color_valid  producer offers a target colour
//               color_ready  block accepts a target this cycle
//               color_rgb    target colour {red, green, blue}
//               pwm_red      red PWM
//               pwm_green    green PWM
//               pwm_blue     blue PWM
//               busy         fade in progress
// Build option: define RGB_PWM_GAMMA_EN to apply the square-law duty map
//               eff(c) = (c*c + 255) >> 8. Otherwise eff(c) = c.
// ============================================================================
module rgb_pwm_fader #(
   parameter int PWM_PRESCALE = 4,
   parameter int FADE_DIV     = 180
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        color_valid,
   output logic        color_ready,
   input  logic [23:0] color_rgb,
   output logic        pwm_red,
   output logic        pwm_green,
   output logic        pwm_blue,
   output logic        busy
);

   localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
   localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_PRESCALE - 1);
   localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_FADE = 1'b1
   } state_t;

   // Duty seen by the pin. With gamma the square is taken at 16 bits and the
   // top byte is kept. The +255 makes any non-zero code stay visibly non-zero.
   function automatic logic [7:0] eff(input logic [7:0] c);
`ifdef RGB_PWM_GAMMA_EN
      return 8'((({8'd0, c} * {8'd0, c}) + 16'd255) >> 8);
`else
      return c;
`endif
   endfunction

   // Move one code toward the target. Equal channels hold.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)
         return cur + 8'd1;
      else if (cur > tgt)
         return cur - 8'd1;
      else
         return cur;
   endfunction

   // ------------------------------------------------------------------
   // Timebase: prescaler -> 8-bit PWM counter -> fade pacing counter
   // ------------------------------------------------------------------
   logic [PRE_W-1:0]  pre_cnt_q,  pre_cnt_d;
   logic [7:0]        pwm_cnt_q,  pwm_cnt_d;
   logic [FADE_W-1:0] fade_cnt_q, fade_cnt_d;
   logic              tick, period_end, fade_step;

   always_comb begin
      tick       = (pre_cnt_q == PRE_LAST);
      period_end = tick && (pwm_cnt_q == 8'hFF);
      fade_step  = period_end && (fade_cnt_q == FADE_LAST);
      pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
      pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      fade_cnt_d = fade_cnt_q;
      if (period_end)
         fade_cnt_d = fade_step ? '0 : fade_cnt_q + 1'b1;
   end

   // The counters run freely and never restart on a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q  <= '0;
         pwm_cnt_q  <= '0;
         fade_cnt_q <= '0;
      end else begin
         pre_cnt_q  <= pre_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         fade_cnt_q <= fade_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Handshake / fade sequencer
   // ------------------------------------------------------------------
   state_t     state_q;
   logic       color_ready_q, busy_q;
   logic [7:0] tgt_r_q, tgt_g_q, tgt_b_q;
   logic [7:0] cur_r_q, cur_g_q, cur_b_q;
   logic       at_target;

   assign at_target = (cur_r_q == tgt_r_q) && (cur_g_q == tgt_g_q) && (cur_b_q == tgt_b_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         color_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         tgt_r_q       <= 8'd0;
         tgt_g_q       <= 8'd0;
         tgt_b_q       <= 8'd0;
         cur_r_q       <= 8'd0;
         cur_g_q       <= 8'd0;
         cur_b_q       <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Acceptance uses the registered ready. This makes the first
               // acceptance possible one cycle after reset release.
               if (color_ready_q && color_valid) begin
                  tgt_r_q       <= color_rgb[23:16];
                  tgt_g_q       <= color_rgb[15:8];
                  tgt_b_q       <= color_rgb[7:0];
                  state_q       <= S_FADE;
                  color_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
               end else begin
                  color_ready_q <= 1'b1;
               end
            end
            S_FADE: begin
               // Completion is judged on registered values. A target equal
               // to the current colour therefore costs exactly one FADE cycle.
               if (at_target) begin
                  state_q       <= S_IDLE;
                  busy_q        <= 1'b0;
                  color_ready_q <= 1'b1;
               end else if (fade_step) begin
                  cur_r_q <= step_toward(cur_r_q, tgt_r_q);
                  cur_g_q <= step_toward(cur_g_q, tgt_g_q);
                  cur_b_q <= step_toward(cur_b_q, tgt_b_q);
               end
            end
            default: begin
               state_q       <= S_IDLE;
               busy_q        <= 1'b0;
               color_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign color_ready = color_ready_q;
   assign busy        = busy_q;

   // ------------------------------------------------------------------
   // PWM: shadow duties reload only at a period end, so a running period
   // is never cut short or stretched by a duty change.
   // ------------------------------------------------------------------
   logic [7:0] sh_r_q, sh_g_q, sh_b_q;
   logic       pwm_r_q, pwm_g_q, pwm_b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_r_q  <= 8'd0;
         sh_g_q  <= 8'd0;
         sh_b_q  <= 8'd0;
         pwm_r_q <= 1'b0;
         pwm_g_q <= 1'b0;
         pwm_b_q <= 1'b0;
      end else begin
         if (period_end) begin
            sh_r_q <= eff(cur_r_q);
            sh_g_q <= eff(cur_g_q);
            sh_b_q <= eff(cur_b_q);
         end
         pwm_r_q <= (pwm_cnt_q < sh_r_q);
         pwm_g_q <= (pwm_cnt_q < sh_g_q);
         pwm_b_q <= (pwm_cnt_q < sh_b_q);
      end
   end

   assign pwm_red   = pwm_r_q;
   assign pwm_green = pwm_g_q;
   assign pwm_blue  = pwm_b_q;

endmodule
`default_nettype wire
